// File: rtl/draw_pkg.sv
// Shared drawing-pipeline constants: pixel bus widths, arbiter states, requester ids, tile colours.
package draw_pkg;

  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned CLR_W = 3;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t StIdle    = 2'd0;
  localparam arb_state_t StGrant   = 2'd1;
  localparam arb_state_t StRelease = 2'd2;

  localparam int unsigned REQ_MAZE    = 0;
  localparam int unsigned REQ_ERASE   = 1;
  localparam int unsigned REQ_DRAW    = 2;
  localparam int unsigned REQ_SPECIAL = 3;
  localparam int unsigned REQ_SCREEN  = 4;

  localparam logic [CLR_W-1:0] CLR_BLACK  = 3'b000;
  localparam logic [CLR_W-1:0] CLR_WALL   = 3'b001;
  localparam logic [CLR_W-1:0] CLR_EXIT   = 3'b010;
  localparam logic [CLR_W-1:0] CLR_PLAYER = 3'b100;
  localparam logic [CLR_W-1:0] CLR_PATH   = 3'b111;

  // Index of the lowest set bit; 0 when none is set.
  function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pixel_port_arbiter_if.sv
// Engine-side request/coordinate bundle and the shared registered pixel bus.
interface pixel_port_arbiter_if import draw_pkg::*; #(
  parameter int unsigned NUM_REQ = 5
) ();

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ*X_W-1:0]   x_in;
  logic [NUM_REQ*Y_W-1:0]   y_in;
  logic [NUM_REQ*CLR_W-1:0] clr_in;
  logic [NUM_REQ-1:0]       grant;
  logic [X_W-1:0]           x;
  logic [Y_W-1:0]           y;
  logic [CLR_W-1:0]         colour;
  logic                     plot;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    output req, done, x_in, y_in, clr_in,
    input  grant, x, y, colour, plot, busy, timeout_err
  );

  modport slave (
    input  req, done, x_in, y_in, clr_in,
    output grant, x, y, colour, plot, busy, timeout_err
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first set request strictly after rr_ptr, wrapping modulo NUM_REQ.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      if (!valid && req[(int'(rr_ptr) + k) % int'(NUM_REQ)]) begin
        winner[(int'(rr_ptr) + k) % int'(NUM_REQ)] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_port_arbiter.sv
// Grants the single VGA pixel-write port to one drawing engine at a time and registers its pixels.
module pixel_port_arbiter import draw_pkg::*; #(
  parameter int unsigned NUM_REQ        = 5,
  parameter int unsigned TIMEOUT_CYCLES = 131072
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_port_arbiter_if.slave  bus
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [TW-1:0]      timer_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [CLR_W-1:0]   colour_q;
  logic               plot_q;
  logic               timeout_err_q;

  logic [NUM_REQ-1:0] winner;
  logic               win_valid;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [CLR_W-1:0]   sel_clr;
  logic               g_done;
  logic               g_req;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .valid  (win_valid)
  );

  // rr_ptr_q always names the granted engine while in GRANT.
  always_comb begin
    sel_x   = bus.x_in[rr_ptr_q * X_W +: X_W];
    sel_y   = bus.y_in[rr_ptr_q * Y_W +: Y_W];
    sel_clr = bus.clr_in[rr_ptr_q * CLR_W +: CLR_W];
    g_done  = bus.done[rr_ptr_q];
    g_req   = bus.req[rr_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      rr_ptr_q      <= PW'(NUM_REQ - 1);
      timer_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      colour_q      <= '0;
      plot_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          plot_q <= 1'b0;
          if (win_valid) begin
            grant_q  <= winner;
            rr_ptr_q <= PW'(onehot_to_idx(32'(winner)));
            timer_q  <= '0;
            state_q  <= StGrant;
          end
        end
        StGrant: begin
          if (g_done) begin
            // Pixel presented alongside done is still written.
            x_q      <= sel_x;
            y_q      <= sel_y;
            colour_q <= sel_clr;
            plot_q   <= 1'b1;
            grant_q  <= '0;
            state_q  <= StRelease;
          end else if (!g_req) begin
            plot_q  <= 1'b0;
            grant_q <= '0;
            state_q <= StRelease;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            plot_q        <= 1'b0;
            grant_q       <= '0;
            timeout_err_q <= 1'b1;
            state_q       <= StRelease;
          end else begin
            x_q      <= sel_x;
            y_q      <= sel_y;
            colour_q <= sel_clr;
            plot_q   <= 1'b1;
            timer_q  <= timer_q + 1'b1;
          end
        end
        StRelease: begin
          plot_q  <= 1'b0;
          grant_q <= '0;
          state_q <= StIdle;
        end
        default: begin
          plot_q  <= 1'b0;
          grant_q <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.colour      = colour_q;
  assign bus.plot        = plot_q;
  assign bus.busy        = (state_q == StGrant) || (state_q == StRelease);
  assign bus.timeout_err = timeout_err_q;

endmodule
